mem_wb_stage: RTL and testbench

- Back end of the five-stage pipeline; consumes the EX stage result bundle (ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR, EXE_ins_*).
- Contains the EX/MEM register, a word-addressed data memory with configurable wait states, and the MEM/WB register.
- Drives writeback, forwarding taps, and a stall request back to the upstream stages.

---
 rtl/mem_wb_stage.sv | 109 ++++++++++
 tb/tb_mem_wb_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM register, wait-stated word-addressed data memory and MEM/WB register.
// Stalls upstream while an access is waiting; forwarding taps come straight off EX/MEM.
module mem_wb_stage #(
    parameter int DADDR_W = 6,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic [31:0] ex_aluR,
    input  logic [31:0] ex_inB,
    input  logic [4:0]  ex_destR,
    input  logic [3:0]  EXE_ins_type,
    input  logic [3:0]  EXE_ins_number,
    output logic        mem_stall,
    output logic        mem_wreg,
    output logic [4:0]  mem_destR,
    output logic [31:0] mem_aluR,
    output logic [3:0]  MEM_ins_type,
    output logic [3:0]  MEM_ins_number,
    output logic        wb_wreg,
    output logic [4:0]  wb_destR,
    output logic [31:0] wb_data,
    output logic [3:0]  WB_ins_type,
    output logic [3:0]  WB_ins_number
);
    localparam logic [2:0] LAT = 3'(LATENCY);

    logic        m_wreg_q, m_m2reg_q, m_wmem_q;
    logic [31:0] m_aluR_q, m_inB_q;
    logic [4:0]  m_destR_q;
    logic [3:0]  m_type_q, m_num_q;
    logic [2:0]  cnt_q;
    logic        wb_wreg_q, wb_wreg_d;
    logic [4:0]  wb_destR_q, wb_destR_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  wb_type_q, wb_type_d, wb_num_q, wb_num_d;
    logic [31:0] mem_q [2**DADDR_W];
    logic [DADDR_W-1:0] idx;
    logic        acc;

    assign idx       = m_aluR_q[DADDR_W+1:2];
    assign acc       = m_wmem_q | m_m2reg_q;
    assign mem_stall = acc && (cnt_q != LAT);

    // a stalled MEM stage hands WB a bubble each wait cycle
    always_comb begin
        wb_wreg_d  = !mem_stall && m_wreg_q;
        wb_destR_d = mem_stall ? 5'd0 : m_destR_q;
        wb_data_d  = mem_stall ? 32'd0 : (m_m2reg_q ? mem_q[idx] : m_aluR_q);
        wb_type_d  = mem_stall ? 4'd0 : m_type_q;
        wb_num_d   = mem_stall ? 4'd0 : m_num_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_wreg_q   <= 1'b0;
            m_m2reg_q  <= 1'b0;
            m_wmem_q   <= 1'b0;
            m_aluR_q   <= '0;
            m_inB_q    <= '0;
            m_destR_q  <= '0;
            m_type_q   <= '0;
            m_num_q    <= '0;
            cnt_q      <= '0;
            wb_wreg_q  <= 1'b0;
            wb_destR_q <= '0;
            wb_data_q  <= '0;
            wb_type_q  <= '0;
            wb_num_q   <= '0;
        end else begin
            if (!mem_stall) begin
                m_wreg_q  <= ex_wreg;
                m_m2reg_q <= ex_m2reg;
                m_wmem_q  <= ex_wmem;
                m_aluR_q  <= ex_aluR;
                m_inB_q   <= ex_inB;
                m_destR_q <= ex_destR;
                m_type_q  <= EXE_ins_type;
                m_num_q   <= EXE_ins_number;
            end
            cnt_q      <= mem_stall ? cnt_q + 3'd1 : 3'd0;
            wb_wreg_q  <= wb_wreg_d;
            wb_destR_q <= wb_destR_d;
            wb_data_q  <= wb_data_d;
            wb_type_q  <= wb_type_d;
            wb_num_q   <= wb_num_d;
        end
    end

    // store lands only on the completing edge; a reset edge drops it
    always_ff @(posedge clk) begin
        if (rst && acc && !mem_stall && m_wmem_q)
            mem_q[idx] <= m_inB_q;
    end

    assign mem_wreg       = m_wreg_q;
    assign mem_destR      = m_destR_q;
    assign mem_aluR       = m_aluR_q;
    assign MEM_ins_type   = m_type_q;
    assign MEM_ins_number = m_num_q;
    assign wb_wreg        = wb_wreg_q;
    assign wb_destR       = wb_destR_q;
    assign wb_data        = wb_data_q;
    assign WB_ins_type    = wb_type_q;
    assign WB_ins_number  = wb_num_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage at LATENCY 1 (u0), 3 (u1) and 0 (u2).
// All three instances share the stimulus; each scenario checks only the instance it targets.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_wreg = 1'b0, ex_m2reg = 1'b0, ex_wmem = 1'b0;
    logic [31:0] ex_aluR = '0, ex_inB = '0;
    logic [4:0]  ex_destR = '0;
    logic [3:0]  ex_type = '0, ex_num = '0;

    logic        stall [3];
    logic        mwreg [3];
    logic [4:0]  mdest [3];
    logic [31:0] malu  [3];
    logic [3:0]  mtype [3];
    logic [3:0]  mnum  [3];
    logic        wwreg [3];
    logic [4:0]  wdest [3];
    logic [31:0] wdata [3];
    logic [3:0]  wtype [3];
    logic [3:0]  wnum  [3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_wb_stage #(.DADDR_W(6), .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 0)) u_dut (
            .clk(clk), .rst(rst),
            .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
            .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
            .EXE_ins_type(ex_type), .EXE_ins_number(ex_num),
            .mem_stall(stall[g]), .mem_wreg(mwreg[g]), .mem_destR(mdest[g]),
            .mem_aluR(malu[g]), .MEM_ins_type(mtype[g]), .MEM_ins_number(mnum[g]),
            .wb_wreg(wwreg[g]), .wb_destR(wdest[g]), .wb_data(wdata[g]),
            .WB_ins_type(wtype[g]), .WB_ins_number(wnum[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic m2r, input logic wm, input logic [31:0] alu,
                         input logic [31:0] b, input logic [4:0] d, input logic [3:0] t, input logic [3:0] n);
        ex_wreg = wr; ex_m2reg = m2r; ex_wmem = wm; ex_aluR = alu;
        ex_inB = b; ex_destR = d; ex_type = t; ex_num = n;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        nop();
        repeat (6) tick();
    endtask

    // capture the driven instruction, wait out its stall on instance k, then take the completing edge
    task automatic issue(input int k);
        int n;
        tick();
        nop();
        n = 0;
        while (stall[k] && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) begin
            checks++; fails++;
            $display("FAIL issue_timeout u%0d: stall still %b after %0d cycles", k, stall[k], n);
        end
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 4'h9, 4'h9);
        tick();
        tick();
        checks++;
        if ({mwreg[0], mdest[0], malu[0], mtype[0], mnum[0], wwreg[0], wdest[0], wdata[0], wtype[0], wnum[0]} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got wb_wreg=%b wb_data=%h mem_aluR=%h required all zero", wwreg[0], wdata[0], malu[0]);
        end
        checks++;
        if ({stall[0], stall[1], stall[2]} !== 3'b000) begin
            fails++;
            $display("FAIL reset_stall: got %b%b%b required 000", stall[0], stall[1], stall[2]);
        end
        rst = 1'b1;
        drive(1, 0, 0, 32'h5, 0, 5'd3, 4'h2, 4'h1);
        tick();
        nop();
        checks++;
        if (mwreg[0] !== 1'b1 || malu[0] !== 32'h5 || mdest[0] !== 5'd3) begin
            fails++;
            $display("FAIL reset_alu_mem_tap: got wreg=%b aluR=%h destR=%0d required 1 5 3", mwreg[0], malu[0], mdest[0]);
        end
        tick();
        checks++;
        if (wwreg[0] !== 1'b1 || wdest[0] !== 5'd3 || wdata[0] !== 32'h5 || wtype[0] !== 4'h2 || wnum[0] !== 4'h1) begin
            fails++;
            $display("FAIL reset_alu_wb: got %b %0d %h %h %h required 1 3 5 2 1", wwreg[0], wdest[0], wdata[0], wtype[0], wnum[0]);
        end
    endtask

    task automatic test_store_load();
        settle();
        drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 4'h3, 4'h2);
        tick();
        checks++;
        if (stall[0] !== 1'b1) begin
            fails++;
            $display("FAIL sw_stall_first: got %b required 1", stall[0]);
        end
        tick();
        checks++;
        if (stall[0] !== 1'b0 || wwreg[0] !== 1'b0) begin
            fails++;
            $display("FAIL sw_stall_len: got stall=%b wb_wreg=%b required 0 0", stall[0], wwreg[0]);
        end
        drive(1, 1, 0, 32'h10, 0, 5'd8, 4'h4, 4'h3);
        tick();
        nop();
        checks++;
        if (stall[0] !== 1'b1 || wwreg[0] !== 1'b0) begin
            fails++;
            $display("FAIL lw_stall: got stall=%b wb_wreg=%b required 1 0", stall[0], wwreg[0]);
        end
        tick();
        checks++;
        if (stall[0] !== 1'b0 || wwreg[0] !== 1'b0) begin
            fails++;
            $display("FAIL lw_bubble: got stall=%b wb_wreg=%b required 0 0", stall[0], wwreg[0]);
        end
        tick();
        checks++;
        if (wwreg[0] !== 1'b1 || wdest[0] !== 5'd8 || wdata[0] !== 32'hDEAD_BEEF || wtype[0] !== 4'h4) begin
            fails++;
            $display("FAIL lw_data: got %b %0d %h %h required 1 8 deadbeef 4", wwreg[0], wdest[0], wdata[0], wtype[0]);
        end
    endtask

    task automatic test_wrap();
        settle();
        drive(0, 0, 1, 32'h103, 32'h1234_5678, 0, 0, 0);
        issue(0);
        drive(1, 1, 0, 32'h0, 0, 5'd9, 0, 0);
        issue(0);
        checks++;
        if (wdata[0] !== 32'h1234_5678 || wdest[0] !== 5'd9) begin
            fails++;
            $display("FAIL wrap_align: got %h dest %0d required 12345678 dest 9", wdata[0], wdest[0]);
        end
    endtask

    task automatic test_stall_hold();
        int bubbles;
        settle();
        drive(0, 0, 1, 32'h40, 32'h1111, 0, 0, 0);
        issue(1);
        drive(1, 1, 1, 32'h40, 32'h2222, 5'd5, 0, 0);
        issue(1);
        checks++;
        if (wdata[1] !== 32'h1111 || wdest[1] !== 5'd5) begin
            fails++;
            $display("FAIL swlw_old_value: got %h dest %0d required 1111 dest 5", wdata[1], wdest[1]);
        end
        drive(1, 1, 0, 32'h40, 0, 5'd6, 4'h7, 4'h7);
        tick();
        drive(1, 0, 1, 32'hFFF, 32'hBAD, 5'd31, 4'hF, 4'hF);
        bubbles = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall[1] !== 1'b1 || malu[1] !== 32'h40 || mdest[1] !== 5'd6 || mtype[1] !== 4'h7 || mnum[1] !== 4'h7) begin
                fails++;
                $display("FAIL hold_taps[%0d]: got stall=%b aluR=%h dest=%0d tag=%h required 1 40 6 7", i, stall[1], malu[1], mdest[1], mtype[1]);
            end
            tick();
            if (wwreg[1] === 1'b0 && wdest[1] === 5'd0) bubbles++;
        end
        checks++;
        if (bubbles !== 3 || stall[1] !== 1'b0) begin
            fails++;
            $display("FAIL hold_bubbles: got %0d bubbles stall=%b required 3 bubbles stall 0", bubbles, stall[1]);
        end
        tick();
        nop();
        checks++;
        if (wwreg[1] !== 1'b1 || wdest[1] !== 5'd6 || wdata[1] !== 32'h2222 || malu[1] !== 32'hFFF) begin
            fails++;
            $display("FAIL hold_result: got %b %0d %h alu %h required 1 6 2222 alu fff", wwreg[1], wdest[1], wdata[1], malu[1]);
        end
        settle();
    endtask

    task automatic test_lat0();
        logic [31:0] alu [6] = '{32'h8, 32'h8, 32'h77, 32'hC, 32'hC, 32'h1234};
        logic [31:0] inb [6] = '{32'hA5A5_A5A5, 32'h0, 32'h0, 32'h5A5A_5A5A, 32'h0, 32'h0};
        logic [2:0]  ctl [6] = '{3'b001, 3'b110, 3'b100, 3'b001, 3'b110, 3'b100};
        logic [4:0]  dst [6] = '{5'd0, 5'd10, 5'd11, 5'd0, 5'd12, 5'd13};
        logic [31:0] exp [6] = '{32'h8, 32'hA5A5_A5A5, 32'h77, 32'hC, 32'h5A5A_5A5A, 32'h1234};
        settle();
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(ctl[i][2], ctl[i][1], ctl[i][0], alu[i], inb[i], dst[i], 0, 0);
            else nop();
            tick();
            checks++;
            if (stall[2] !== 1'b0) begin
                fails++;
                $display("FAIL lat0_stall[%0d]: got %b required 0", i, stall[2]);
            end
            if (i >= 1) begin
                checks++;
                if (wwreg[2] !== ctl[i-1][2] || wdest[2] !== dst[i-1] || wdata[2] !== exp[i-1]) begin
                    fails++;
                    $display("FAIL lat0_wb[%0d]: got %b %0d %h required %b %0d %h", i - 1,
                             wwreg[2], wdest[2], wdata[2], ctl[i-1][2], dst[i-1], exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        drive(0, 0, 1, 32'h20, 32'h1111_2222, 0, 0, 0);
        issue(0);
        drive(0, 0, 1, 32'h20, 32'hAAAA_5555, 0, 0, 0);
        tick();
        nop();
        checks++;
        if (stall[0] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_stall_before: got %b required 1", stall[0]);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (stall[0] !== 1'b0 || mwreg[0] !== 1'b0 || malu[0] !== 32'h0 || wwreg[0] !== 1'b0) begin
            fails++;
            $display("FAIL midrst_cleared: got stall=%b mwreg=%b alu=%h wwreg=%b required 0 0 0 0", stall[0], mwreg[0], malu[0], wwreg[0]);
        end
        drive(1, 1, 0, 32'h20, 0, 5'd4, 0, 0);
        tick();
        nop();
        checks++;
        if (stall[0] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_cnt_restart: got stall=%b required 1", stall[0]);
        end
        tick();
        tick();
        checks++;
        if (wwreg[0] !== 1'b1 || wdest[0] !== 5'd4 || wdata[0] !== 32'h1111_2222) begin
            fails++;
            $display("FAIL midrst_store_dropped: got %b %0d %h required 1 4 11112222", wwreg[0], wdest[0], wdata[0]);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_stall_hold();
        test_lat0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
